cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Grant side of the common data bus (CDB) request/transmit handshake.
//  Functional units (adders, multipliers, load buffers) raise CDB_rts when a result is ready.
//  This block picks one of them round-robin and drives its one-hot CDB_xmit for the broadcast window.
//  It then drops CDB_xmit; the falling edge is what releases the winning unit's reservation station.
//  Sits between the functional units and the tri-state CDB.
// PARAMETERS
//  NUM_UNITS    4   number of requesting functional units (2..8)
//  HOLD_CYCLES  1   clock cycles CDB_xmit stays high per grant (1..15)
//  CNT_W        16  width of the broadcast statistics counter
// PORTS
//  clock        in   1                  system clock, all state on posedge
//  reset        in   1                  synchronous, active-high
//  CDB_rts      in   NUM_UNITS          per-unit request-to-send, level
//  CDB_write    in   1                  CDB write strobe (monitor only)
//  CDB_xmit     out  NUM_UNITS          one-hot grant; at most one bit high
//  grant_id     out  $clog2(NUM_UNITS)  index of current/last grantee
//  bus_busy     out  1                  high while any CDB_xmit bit is high
//  bus_error    out  1                  one-cycle pulse on a protocol violation
//  broadcasts   out  CNT_W              completed grants since reset, wraps
// BEHAVIOUR
//  Reset: CDB_xmit=0, grant_id=0, bus_busy=0, bus_error=0, broadcasts=0, rr_ptr=0, state=IDLE.
//    Reset mid-grant drops CDB_xmit at that same edge; no broadcast is counted.
//  FSM (posedge clock):
//    IDLE: if any CDB_rts is set, pick the first requester at or after rr_ptr (wrapping modulo NUM_UNITS).
//      Assert its CDB_xmit bit, load grant_id, load hold_cnt=HOLD_CYCLES-1, go to GRANT.
//      Latency: rts sampled at edge N gives xmit high after edge N.
//    GRANT: hold CDB_xmit.
//      If hold_cnt==0, or the grantee's rts is already low: clear CDB_xmit, go to RELEASE,
//      set rr_ptr=grant_id+1 (wrapping), and increment broadcasts (wraps at 2^CNT_W).
//      Otherwise decrement hold_cnt.
//    RELEASE: exactly one cycle with CDB_xmit=0 so the unit can clear rts on the xmit falling edge.
//      The previous grantee's rts is ignored during this cycle. Go to IDLE.
//  Fairness: back-to-back requesters are served in rotating order; no unit waits more than NUM_UNITS grants.
//  Simultaneous requests: the lowest index at or after rr_ptr wins.
//  Grantee keeps rts high after RELEASE: it is treated as a new request and waits its turn.
//  bus_error pulses for one cycle when either of these is sampled:
//    CDB_write=1 in IDLE (a driver without a grant);
//    the grantee's rts is low on the first GRANT cycle (a request was withdrawn).
//  Invariant: $onehot0(CDB_xmit) always holds; bus_busy == |CDB_xmit.
// STRUCTURE
//  Shared package cdb_pkg: state encoding (IDLE/GRANT/RELEASE), default NUM_UNITS.
//    The package also holds the unit-id constants shared with the reservation stations (no_rs=0, adder_1..3).
//  Sub-module rr_pick: combinational round-robin priority picker.
//    Inputs: req vector and rr_ptr. Outputs: valid and index.
//  The arbiter keeps the FSM, hold counter, grant register and statistics.
// TESTING
//  1 Single request: rts=4'b0010 at cycle 3 -> xmit=4'b0010 cycles 4..4+HOLD_CYCLES-1.
//    Then xmit=0 for one cycle, broadcasts=1, rr_ptr=2.
//  2 All request: rts=4'b1111 held, rr_ptr=0 -> grant order 0,1,2,3,0.
//    Each grant is followed by one idle RELEASE cycle.
//  3 Wrap: rr_ptr=3 with rts=4'b1001 -> unit 3 granted first, then unit 0.
//  4 HOLD_CYCLES=3: grantee drops rts after 1 cycle -> xmit falls the next edge, broadcasts still increments.
//  5 Reset asserted in the 2nd GRANT cycle -> xmit=0 and broadcasts=0 after that edge.
//    Re-request after reset is granted to unit 0 first.
//  6 CDB_write=1 in IDLE with rts=0 -> bus_error=1 for exactly one cycle, no grant issued.
//  Assertions throughout: $onehot0(CDB_xmit); no grant issued while in RELEASE.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared definitions for the CDB grant logic.
// State encoding, default unit count and reservation-station unit ids.
package cdb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int NUM_UNITS_DEF = 4;

  // Unit ids as seen by the reservation stations
  localparam logic [2:0] no_rs   = 3'd0;
  localparam logic [2:0] adder_1 = 3'd1;
  localparam logic [2:0] adder_2 = 3'd2;
  localparam logic [2:0] adder_3 = 3'd3;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin priority picker: first set request
// at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int j;

  // Walk from the farthest offset down so the nearest one wins
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB grant arbiter: round-robin one-hot xmit per result,
// held for HOLD_CYCLES, then one release cycle.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_UNITS   = NUM_UNITS_DEF,
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 16,
  localparam int IW = $clog2(NUM_UNITS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_UNITS-1:0] CDB_rts,
  input  logic                 CDB_write,
  output logic [NUM_UNITS-1:0] CDB_xmit,
  output logic [IW-1:0]        grant_id,
  output logic                 bus_busy,
  output logic                 bus_error,
  output logic [CNT_W-1:0]     broadcasts
);

  localparam logic [NUM_UNITS-1:0] LSB = 1;
  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_UNITS - 1);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [3:0]    hold_cnt;
  logic          first;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          gnt_rts;
  logic [IW-1:0] nxt_ptr;

  rr_pick #(.N(NUM_UNITS), .IW(IW)) u_pick (
    .req   (CDB_rts),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign gnt_rts = CDB_rts[grant_id];
  assign nxt_ptr = (grant_id == LAST) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      CDB_xmit   <= '0;
      grant_id   <= '0;
      bus_busy   <= 1'b0;
      bus_error  <= 1'b0;
      broadcasts <= '0;
      rr_ptr     <= '0;
      hold_cnt   <= '0;
      first      <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CDB_write)
            bus_error <= 1'b1;
          if (pick_valid) begin
            CDB_xmit <= LSB << pick_idx;
            grant_id <= pick_idx;
            hold_cnt <= HOLD_LD;
            first    <= 1'b1;
            bus_busy <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          first <= 1'b0;
          // Withdrawn request on the first grant cycle
          if (first && !gnt_rts)
            bus_error <= 1'b1;
          if (hold_cnt == 4'd0 || !gnt_rts) begin
            CDB_xmit   <= '0;
            bus_busy   <= 1'b0;
            rr_ptr     <= nxt_ptr;
            broadcasts <= broadcasts + 1'b1;
            state      <= RELEASE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table on a
// HOLD_CYCLES=1 instance, hand sequences on HOLD_CYCLES=3.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic        clock = 1'b0;
  logic        rst, rst3;
  logic [3:0]  rts, rts3;
  logic        wr, wr3;
  logic [3:0]  xmit, xmit3;
  logic [1:0]  gid, gid3;
  logic        busy, busy3;
  logic        err, err3;
  logic [15:0] bc, bc3;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_UNITS(4), .HOLD_CYCLES(1), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (rst),
    .CDB_rts    (rts),
    .CDB_write  (wr),
    .CDB_xmit   (xmit),
    .grant_id   (gid),
    .bus_busy   (busy),
    .bus_error  (err),
    .broadcasts (bc)
  );

  cdb_arbiter #(.NUM_UNITS(4), .HOLD_CYCLES(3), .CNT_W(16)) dut3 (
    .clock      (clock),
    .reset      (rst3),
    .CDB_rts    (rts3),
    .CDB_write  (wr3),
    .CDB_xmit   (xmit3),
    .grant_id   (gid3),
    .bus_busy   (busy3),
    .bus_error  (err3),
    .broadcasts (bc3)
  );

  a_oh:    assert property (@(posedge clock) $onehot0(xmit));
  a_oh3:   assert property (@(posedge clock) $onehot0(xmit3));
  a_busy:  assert property (@(posedge clock) busy == |xmit);
  a_busy3: assert property (@(posedge clock) busy3 == |xmit3);
  a_rel:   assert property (@(posedge clock) disable iff (rst)
             dut.state == RELEASE |=> xmit == 4'b0);
  a_rel3:  assert property (@(posedge clock) disable iff (rst3)
             dut3.state == RELEASE |=> xmit3 == 4'b0);

  typedef struct {
    logic        rst;
    logic [3:0]  rts;
    logic        wr;
    logic [3:0]  xmit;
    logic [1:0]  gid;
    logic        err;
    logic [15:0] bc;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic [3:0] q,
                     input logic w, input logic [3:0] x,
                     input logic [1:0] g, input logic e,
                     input logic [15:0] b);
    vec_t v;
    v.rst = r; v.rts = q; v.wr = w; v.xmit = x;
    v.gid = g; v.err = e; v.bc = b;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk3(input string name, input logic [3:0] x,
                      input logic [1:0] g, input logic [15:0] b);
    chk({name, " xmit3"}, 32'(xmit3), 32'(x));
    chk({name, " gid3"}, 32'(gid3), 32'(g));
    chk({name, " bc3"}, 32'(bc3), 32'(b));
    chk({name, " busy3"}, 32'(busy3), 32'(|x));
  endtask

  initial begin
    // rst rts wr | xmit gid err bc
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 0, 0);
    add(0, 4'b0010, 0, 4'b0000, 1, 0, 1);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 1);
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 0, 0);
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b1111, 0, 4'b0010, 1, 0, 1);
    add(0, 4'b1111, 0, 4'b0000, 1, 0, 2);
    add(0, 4'b1111, 0, 4'b0000, 1, 0, 2);
    add(0, 4'b1111, 0, 4'b0100, 2, 0, 2);
    add(0, 4'b1111, 0, 4'b0000, 2, 0, 3);
    add(0, 4'b1111, 0, 4'b0000, 2, 0, 3);
    add(0, 4'b1111, 0, 4'b1000, 3, 0, 3);
    add(0, 4'b1111, 0, 4'b0000, 3, 0, 4);
    add(0, 4'b1111, 0, 4'b0000, 3, 0, 4);
    add(0, 4'b1111, 0, 4'b0001, 0, 0, 4);
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 5);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 5);
    add(0, 4'b0100, 0, 4'b0100, 2, 0, 5);
    add(0, 4'b0100, 0, 4'b0000, 2, 0, 6);
    add(0, 4'b0000, 0, 4'b0000, 2, 0, 6);
    add(0, 4'b1001, 0, 4'b1000, 3, 0, 6);
    add(0, 4'b1001, 0, 4'b0000, 3, 0, 7);
    add(0, 4'b0001, 0, 4'b0000, 3, 0, 7);
    add(0, 4'b0001, 0, 4'b0001, 0, 0, 7);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 8);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 8);
    add(0, 4'b0000, 1, 4'b0000, 0, 1, 8);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 8);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 8);
    add(0, 4'b0010, 0, 4'b0010, 1, 0, 8);
    add(0, 4'b0010, 1, 4'b0000, 1, 0, 9);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 9);

    rst = 1'b1; rst3 = 1'b1;
    rts = '0; rts3 = '0;
    wr = 1'b0; wr3 = 1'b0;
    tick();
    tick();
    chk("rst xmit", 32'(xmit), 0);
    chk("rst gid", 32'(gid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst err", 32'(err), 0);
    chk("rst bc", 32'(bc), 0);
    chk3("rst", 4'b0000, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst;
      rts = vt[i].rts;
      wr  = vt[i].wr;
      tick();
      chk($sformatf("v%0d xmit", i), 32'(xmit), 32'(vt[i].xmit));
      chk($sformatf("v%0d gid", i), 32'(gid), 32'(vt[i].gid));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(|vt[i].xmit));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vt[i].err));
      chk($sformatf("v%0d bc", i), 32'(bc), 32'(vt[i].bc));
    end

    // Early drop with a 3-cycle hold
    rst3 = 1'b0;
    tick();
    rts3 = 4'b0001;
    tick(); chk3("drop g0", 4'b0001, 0, 0);
    tick(); chk3("drop g1", 4'b0001, 0, 0);
    rts3 = 4'b0000;
    tick(); chk3("drop rel", 4'b0000, 0, 1);
    chk("drop err3", 32'(err3), 0);
    tick(); chk3("drop idle", 4'b0000, 0, 1);

    // Full 3-cycle hold
    rts3 = 4'b0010;
    tick(); chk3("hold c0", 4'b0010, 1, 1);
    tick(); chk3("hold c1", 4'b0010, 1, 1);
    tick(); chk3("hold c2", 4'b0010, 1, 1);
    tick(); chk3("hold rel", 4'b0000, 1, 2);
    rts3 = 4'b0000;
    tick(); chk3("hold idle", 4'b0000, 1, 2);

    // Reset in the second grant cycle
    rts3 = 4'b0100;
    tick(); chk3("mid g0", 4'b0100, 2, 2);
    tick(); chk3("mid g1", 4'b0100, 2, 2);
    rst3 = 1'b1;
    tick(); chk3("mid rst", 4'b0000, 0, 0);
    rst3 = 1'b0;
    rts3 = 4'b0101;
    tick(); chk3("post rst", 4'b0001, 0, 0);
    rts3 = 4'b0000;
    tick(); chk3("post rel", 4'b0000, 0, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
